// File: rtl/cleared_sync_memory_pkg.sv
// -----------------------------------------------------------------------------
// memory_pkg
// Shared definitions for cleared_sync_memory:
//   - FSM state encoding (ST_CLEAR / ST_READY)
//   - depth_of(): number of words for a given address width
//   - DEFAULT_INIT_VALUE: value the clear sequencer writes unless overridden
// -----------------------------------------------------------------------------
package memory_pkg;

    // Legacy-compatible state constants; a single bit is enough for two states.
    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    localparam int DEFAULT_INIT_VALUE = 0;

    function automatic int depth_of(input int addr_width);
        return 1 << addr_width;
    endfunction

endpackage

// File: rtl/cleared_sync_memory_if.sv
// -----------------------------------------------------------------------------
// cleared_sync_memory_if
// Request/response bundle between the sample-capture / packetiser side
// (master) and the memory (slave).
//   addr, data_in, write, read, clear : requests, sampled every rising edge
//   data_out, rd_valid                : registered read data + 1-cycle strobe
//   busy                              : memory is clearing, requests dropped
//   err                               : 1-cycle pulse, a request was dropped
//   dbg_state                         : current FSM state, for observation only
//
// Handshake: there is no backpressure. A read or write is accepted in a cycle
// where busy=0 and clear=0; otherwise it is dropped and err pulses the next
// cycle. An accepted read produces rd_valid=1 with data_out exactly one cycle
// later.
// -----------------------------------------------------------------------------
interface cleared_sync_memory_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  write;
    logic                  read;
    logic                  clear;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  rd_valid;
    logic                  busy;
    logic                  err;
    logic [0:0]            dbg_state;

    modport master (
        output addr, data_in, write, read, clear,
        input  data_out, rd_valid, busy, err, dbg_state
    );

    modport slave (
        input  addr, data_in, write, read, clear,
        output data_out, rd_valid, busy, err, dbg_state
    );
endinterface

// File: rtl/cleared_sync_memory_mem_array.sv
// -----------------------------------------------------------------------------
// mem_array
// Plain storage: one synchronous write port, one synchronous read port.
//   clk_i, rst_i       : clock, synchronous active-high reset (read register only)
//   we_i/waddr_i/wdata_i : write port, committed on the rising edge
//   re_i/raddr_i       : read port; rdata_o updates on the edge re_i is high
//   rdata_o            : registered read data, holds when re_i is low
// Reading and writing the same address in one cycle returns the old word,
// because both ports sample the array before the edge's updates land.
// -----------------------------------------------------------------------------
module mem_array
    import memory_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);
    localparam int DEPTH = depth_of(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage itself carries no reset; the clear sequencer initialises it.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/cleared_sync_memory.sv
// -----------------------------------------------------------------------------
// cleared_sync_memory
// Single-port sample memory with registered read, a hardware clear sequencer
// and a dropped-request error pulse.
//   clk      : single clock, rising edge
//   rst      : synchronous active-high reset; restarts the clear sequence
//   mem_if   : slave side of cleared_sync_memory_if (requests, read data,
//              rd_valid, busy, err, dbg_state)
// After reset, or on clear in READY, every word is written with INIT_VALUE,
// one word per cycle, DEPTH cycles in total. Requests seen during that time
// are dropped and flagged on err.
// -----------------------------------------------------------------------------
module cleared_sync_memory
    import memory_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    ADDR_WIDTH = 4,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE = DATA_WIDTH'(DEFAULT_INIT_VALUE)
) (
    input  logic                    clk,
    input  logic                    rst,
    cleared_sync_memory_if.slave    mem_if
);
    localparam int                    DEPTH     = depth_of(ADDR_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  rd_valid_q, rd_valid_d;
    logic                  err_q, err_d;

    logic                  clearing;
    logic                  accept;
    logic                  arr_we;
    logic [ADDR_WIDTH-1:0] arr_waddr;
    logic [DATA_WIDTH-1:0] arr_wdata;
    logic                  arr_re;

    always_comb begin
        clearing = (state_q == ST_CLEAR);
        // A clear request in READY wins over a same-cycle read/write.
        accept   = (state_q == ST_READY) && !mem_if.clear;

        // Write port: sequencer owns it while clearing, user otherwise.
        // Nothing is written on a reset edge.
        arr_we    = !rst && (clearing || (accept && mem_if.write));
        arr_waddr = clearing ? cnt_q : mem_if.addr;
        arr_wdata = clearing ? INIT_VALUE : mem_if.data_in;

        arr_re     = !rst && accept && mem_if.read;
        rd_valid_d = arr_re;
        err_d      = (mem_if.read || mem_if.write) && !accept;

        state_d = state_q;
        cnt_d   = cnt_q;
        if (clearing) begin
            // Counter wraps back to 0 on the last word, ready for the next clear.
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_ADDR) begin
                state_d = ST_READY;
            end
        end else if (mem_if.clear) begin
            state_d = ST_CLEAR;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_CLEAR;
            cnt_q      <= '0;
            rd_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rd_valid_q <= rd_valid_d;
            err_q      <= err_d;
        end
    end

    mem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .re_i    (arr_re),
        .raddr_i (mem_if.addr),
        .rdata_o (mem_if.data_out)
    );

    assign mem_if.rd_valid  = rd_valid_q;
    assign mem_if.err       = err_q;
    assign mem_if.busy      = clearing;
    assign mem_if.dbg_state = state_q;

endmodule

// File: tb/tb_cleared_sync_memory.sv
// -----------------------------------------------------------------------------
// tb_cleared_sync_memory
// Directed bench for cleared_sync_memory with default parameters
// (8-bit data, 16 words, INIT_VALUE 0). Inputs change 1 ns after a rising
// edge and outputs are sampled at that same point, so every sample reflects
// the edge just taken.
// -----------------------------------------------------------------------------
module tb_cleared_sync_memory;
    import memory_pkg::*;

    localparam int DW = 8;
    localparam int AW = 4;
    localparam int DEPTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    cleared_sync_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) mem_if ();

    cleared_sync_memory #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .mem_if (mem_if)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_if.addr    = '0;
        mem_if.data_in = '0;
        mem_if.write   = 1'b0;
        mem_if.read    = 1'b0;
        mem_if.clear   = 1'b0;
    endtask

    // Counts cycles with busy=1, starting from the current sample; bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (mem_if.busy === 1'b1 && n < 40) begin
            n++;
            tick();
        end
    endtask

    // Reads every address back-to-back and expects exp_val at each.
    task automatic read_all(input logic [DW-1:0] exp_val, input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            mem_if.addr = AW'(i);
            mem_if.read = 1'b1;
            tick();
            checks++;
            if (mem_if.rd_valid !== 1'b1 || mem_if.data_out !== exp_val) begin
                errors++;
                $display("FAIL %s addr=%0d: rd_valid=%b data_out=0x%02h, required rd_valid=1 data_out=0x%02h",
                         tag, i, mem_if.rd_valid, mem_if.data_out, exp_val);
            end
        end
        mem_if.read = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int n;
        idle_inputs();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if (mem_if.busy !== 1'b1 || mem_if.rd_valid !== 1'b0 || mem_if.err !== 1'b0 ||
            mem_if.data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b rd_valid=%b err=%b data_out=0x%02h, required 1 0 0 0x00",
                     mem_if.busy, mem_if.rd_valid, mem_if.err, mem_if.data_out);
        end
        checks++;
        if (mem_if.dbg_state !== ST_CLEAR) begin
            errors++;
            $display("FAIL reset_state: state=%b, required %b", mem_if.dbg_state, ST_CLEAR);
        end
        rst = 1'b0;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL reset_busy_len: busy cycles=%0d, required %0d", n, DEPTH);
        end
        read_all(8'h00, "reset_read_init");
        tick();
        checks++;
        if (mem_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL rd_valid_idle: rd_valid=%b, required 0", mem_if.rd_valid);
        end
    endtask

    task automatic test_write_read();
        for (int i = 0; i < DEPTH; i++) begin
            mem_if.addr    = AW'(i);
            mem_if.data_in = DW'(2 * i);
            mem_if.write   = 1'b1;
            tick();
        end
        mem_if.write = 1'b0;
        checks++;
        if (mem_if.rd_valid !== 1'b0 || mem_if.err !== 1'b0) begin
            errors++;
            $display("FAIL write_flags: rd_valid=%b err=%b, required 0 0", mem_if.rd_valid, mem_if.err);
        end
        for (int i = 0; i < DEPTH; i++) begin
            mem_if.addr = AW'(i);
            mem_if.read = 1'b1;
            tick();
            checks++;
            if (mem_if.rd_valid !== 1'b1 || mem_if.data_out !== DW'(2 * i)) begin
                errors++;
                $display("FAIL write_read addr=%0d: rd_valid=%b data_out=0x%02h, required 1 0x%02h",
                         i, mem_if.rd_valid, mem_if.data_out, DW'(2 * i));
            end
        end
        mem_if.read = 1'b0;
        mem_if.addr = 4'd2;
        tick();
        tick();
        checks++;
        if (mem_if.data_out !== 8'h1E || mem_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL data_out_hold: data_out=0x%02h rd_valid=%b, required 0x1e 0",
                     mem_if.data_out, mem_if.rd_valid);
        end
    endtask

    task automatic test_read_write_same();
        mem_if.addr    = 4'd3;
        mem_if.data_in = 8'hAA;
        mem_if.read    = 1'b1;
        mem_if.write   = 1'b1;
        tick();
        mem_if.write = 1'b0;
        checks++;
        if (mem_if.rd_valid !== 1'b1 || mem_if.data_out !== 8'h06) begin
            errors++;
            $display("FAIL read_first: rd_valid=%b data_out=0x%02h, required 1 0x06",
                     mem_if.rd_valid, mem_if.data_out);
        end
        tick();
        mem_if.read = 1'b0;
        checks++;
        if (mem_if.rd_valid !== 1'b1 || mem_if.data_out !== 8'hAA) begin
            errors++;
            $display("FAIL read_after_rw: rd_valid=%b data_out=0x%02h, required 1 0xaa",
                     mem_if.rd_valid, mem_if.data_out);
        end
    endtask

    task automatic test_clear_in_ready();
        int n;
        int err_seen;
        // Put a known value on data_out: addr 7 holds 0x0E.
        mem_if.addr = 4'd7;
        mem_if.read = 1'b1;
        tick();
        mem_if.read = 1'b0;

        mem_if.addr    = 4'd5;
        mem_if.data_in = 8'h77;
        mem_if.write   = 1'b1;
        mem_if.clear   = 1'b1;
        tick();
        mem_if.write = 1'b0;
        mem_if.clear = 1'b0;
        checks++;
        if (mem_if.err !== 1'b1 || mem_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_drop_err: err=%b busy=%b, required 1 1", mem_if.err, mem_if.busy);
        end
        // err must be a single pulse while the clear runs.
        err_seen = 0;
        n = 0;
        while (mem_if.busy === 1'b1 && n < 40) begin
            if (mem_if.err === 1'b1) err_seen++;
            n++;
            tick();
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL clear_busy_len: busy cycles=%0d, required %0d", n, DEPTH);
        end
        checks++;
        if (err_seen != 1) begin
            errors++;
            $display("FAIL clear_err_pulses: err cycles=%0d, required 1", err_seen);
        end
        checks++;
        if (mem_if.data_out !== 8'h0E) begin
            errors++;
            $display("FAIL clear_keeps_data_out: data_out=0x%02h, required 0x0e", mem_if.data_out);
        end
        read_all(8'h00, "clear_read_init");
    endtask

    task automatic test_write_during_clear();
        mem_if.clear = 1'b1;
        tick();
        mem_if.clear = 1'b0;
        // Let the sequencer pass address 2 so an accepted write would survive.
        repeat (5) tick();
        mem_if.addr    = 4'd2;
        mem_if.data_in = 8'h55;
        mem_if.write   = 1'b1;
        tick();
        mem_if.write = 1'b0;
        checks++;
        if (mem_if.err !== 1'b1 || mem_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_write_drop: err=%b rd_valid=%b, required 1 0", mem_if.err, mem_if.rd_valid);
        end
        mem_if.read = 1'b1;
        tick();
        mem_if.read = 1'b0;
        checks++;
        if (mem_if.err !== 1'b1 || mem_if.rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL busy_read_drop: err=%b rd_valid=%b, required 1 0", mem_if.err, mem_if.rd_valid);
        end
        // A clear request while clearing must not restart the sequence:
        // 7 edges used so far, 9 remain.
        mem_if.clear = 1'b1;
        tick();
        mem_if.clear = 1'b0;
        checks++;
        if (mem_if.err !== 1'b0) begin
            errors++;
            $display("FAIL busy_err_single: err=%b, required 0", mem_if.err);
        end
        repeat (7) tick();
        checks++;
        if (mem_if.busy !== 1'b1) begin
            errors++;
            $display("FAIL clear_no_restart_a: busy=%b, required 1", mem_if.busy);
        end
        tick();
        checks++;
        if (mem_if.busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_no_restart_b: busy=%b, required 0", mem_if.busy);
        end
        mem_if.addr = 4'd2;
        mem_if.read = 1'b1;
        tick();
        mem_if.read = 1'b0;
        checks++;
        if (mem_if.rd_valid !== 1'b1 || mem_if.data_out !== 8'h00) begin
            errors++;
            $display("FAIL busy_write_lost: rd_valid=%b data_out=0x%02h, required 1 0x00",
                     mem_if.rd_valid, mem_if.data_out);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        // Leave a nonzero value on data_out so reset has something to clear.
        mem_if.addr    = 4'd9;
        mem_if.data_in = 8'h99;
        mem_if.write   = 1'b1;
        tick();
        mem_if.write = 1'b0;
        mem_if.read  = 1'b1;
        tick();
        mem_if.read  = 1'b0;
        mem_if.clear = 1'b1;
        tick();
        mem_if.clear = 1'b0;
        repeat (7) tick();   // counter now 7
        rst          = 1'b1;
        mem_if.write = 1'b1; // must not raise err during reset
        tick();
        checks++;
        if (mem_if.busy !== 1'b1 || mem_if.rd_valid !== 1'b0 || mem_if.err !== 1'b0 ||
            mem_if.data_out !== 8'h00) begin
            errors++;
            $display("FAIL mid_reset_outputs: busy=%b rd_valid=%b err=%b data_out=0x%02h, required 1 0 0 0x00",
                     mem_if.busy, mem_if.rd_valid, mem_if.err, mem_if.data_out);
        end
        rst          = 1'b0;
        mem_if.write = 1'b0;
        count_busy(n);
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL mid_reset_busy_len: busy cycles=%0d, required %0d", n, DEPTH);
        end
        read_all(8'h00, "mid_reset_read_init");
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        idle_inputs();
        test_reset();
        test_write_read();
        test_read_write_same();
        test_clear_in_ready();
        test_write_during_clear();
        test_reset_mid_clear();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
